aurora_rx_frame_checker: RTL and testbench
==========================================

# aurora_rx_frame_checker

Receive-side frame checker for the Aurora loopback test path. It consumes the Aurora user RX AXI-stream (RX_DATA/RX_TVALID/RX_TKEEP/RX_TLAST) and validates the frame format produced by the TX stimulus side: header word, indexed payload, trailer word with TLAST. It reports per-frame pass/fail pulses and saturating frame and error counters, and optionally measures TX-to-RX latency. It sits in the user clock domain, beside each `aurora_test_*` instance's RX interface.

## Interface
- HEADER, 32'hCAFEBABE, required first word of every frame
- TRAILER, 32'hDEADBEEF, required last word (beat with TLAST)
- MAX_PAYLOAD, 256, maximum payload words between header and trailer (1..65535)
- USER_CLK  in  1  Aurora user clock; all logic on rising edge
- RESET  in  1  asynchronous, active-high; clears all state and outputs
- CHANNEL_UP  in  1  Aurora channel status; low aborts the frame in progress
- RX_DATA  in  [0:31]  received word
- RX_TVALID  in  1  beat valid (no backpressure; every valid beat is consumed)
- RX_TKEEP  in  [0:3]  byte enables; must be 4'b1111 on every beat
- RX_TLAST  in  1  last beat of frame
- CLEAR  in  1  synchronous pulse: zero counters, sticky flag, expected sequence
- FRAME_OK  out  1  one-cycle pulse, frame passed
- FRAME_BAD  out  1  one-cycle pulse, frame failed or aborted
- ERR_STICKY  out  1  set by any FRAME_BAD; cleared by CLEAR/RESET
- FRAME_CNT  out  16  completed good frames, saturating at 16'hFFFF
- ERR_CNT  out  16  bad frames, saturating at 16'hFFFF
- LAST_LEN  out  16  payload word count of the most recent completed frame
- START  in  1  (CHECKER_LATENCY_EN only) TX-side first-valid pulse
- LATENCY  out  16  (CHECKER_LATENCY_EN only) cycles from START to RX header

## Operation
- Beat = cycle with RX_TVALID=1. Non-valid cycles hold all state.
- States: HUNT, BODY.
- HUNT: beat with RX_DATA==HEADER and RX_TLAST=0 -> BODY, payload index k=0. Any other beat ignored (no error); header with TLAST=1 -> FRAME_BAD.
- BODY, beat with RX_TLAST=0: payload word k must equal {seq[15:0], k[15:0]}; mismatch sets frame-error flag; k increments. k reaching MAX_PAYLOAD and another non-last beat -> FRAME_BAD, -> HUNT.
- BODY, beat with RX_TLAST=1: word must equal TRAILER. FRAME_OK if no error flag, else FRAME_BAD; LAST_LEN<=k; -> HUNT.
- Any beat with RX_TKEEP!=4'b1111 inside a frame (header through trailer) sets frame-error flag.
- seq: expected sequence, 0 after reset/CLEAR, +1 (mod 2^16) per completed frame. On mismatch, first mismatching payload upper half is captured; seq reloads to captured+1 at frame end (resync).
- CHANNEL_UP low in BODY: FRAME_BAD pulse once, -> HUNT. While low, beats ignored.
- HEADER inside BODY (non-last beat): treated as payload (mismatch unless equal).
- Counters saturate; ERR_CNT increments on every FRAME_BAD.
- CLEAR concurrent with frame end: CLEAR wins for counters/flag/seq; pulse still issued.

## Timing
- Reset values: FRAME_OK=0, FRAME_BAD=0, ERR_STICKY=0, FRAME_CNT=0, ERR_CNT=0, LAST_LEN=0, LATENCY=0, state HUNT.
- All outputs registered. FRAME_OK/FRAME_BAD assert the cycle after the trailer/abort beat, for exactly one cycle. Counters and LAST_LEN update the same cycle as the pulse.
- Back-to-back frames (header the cycle after trailer) sustained at full rate, no dead cycles.
- RESET mid-frame: immediate return to HUNT, no pulse.

## Configuration
- CHECKER_LATENCY_EN defined: START and LATENCY ports exist; 16-bit counter starts at 0 on START, increments each cycle, stops and loads LATENCY on next HUNT->BODY header acceptance; saturates at 16'hFFFF; START while running restarts.
- Undefined: ports and counter absent; all other behaviour identical.

## Test plan
- Beats CAFEBABE, DEADBEEF(TLAST), TKEEP=F -> FRAME_OK one cycle later, FRAME_CNT=1, LAST_LEN=0.
- Two frames: CAFEBABE,00000000,00000001,DEADBEEF then CAFEBABE,00010000,DEADBEEF back-to-back -> two FRAME_OK, FRAME_CNT=2, LAST_LEN=1.
- Payload 00000005 at k=0 -> FRAME_BAD, ERR_CNT=1, ERR_STICKY=1; next frame with seq 0001 passes.
- TKEEP=4'b0111 on trailer -> FRAME_BAD; CHANNEL_UP dropped mid-frame -> FRAME_BAD, next header accepted.
- MAX_PAYLOAD=2, three non-last payload words -> FRAME_BAD, HUNT; CLEAR -> counters 0, ERR_STICKY 0.
- CHECKER_LATENCY_EN: START pulse, header 40 cycles later -> LATENCY=40.

Source files
------------

// File: rtl/aurora_rx_frame_checker.sv
// Aurora RX frame checker: validates header / indexed payload / trailer frames, counts results.
// Optional TX-to-RX latency measurement is compiled in with the CHECKER_LATENCY_EN macro.
module aurora_rx_frame_checker #(
  parameter logic [31:0] HEADER      = 32'hCAFEBABE,
  parameter logic [31:0] TRAILER     = 32'hDEADBEEF,
  parameter int          MAX_PAYLOAD = 256
) (
  input  logic        USER_CLK,
  input  logic        RESET,
  input  logic        CHANNEL_UP,
  input  logic [0:31] RX_DATA,
  input  logic        RX_TVALID,
  input  logic [0:3]  RX_TKEEP,
  input  logic        RX_TLAST,
  input  logic        CLEAR,
`ifdef CHECKER_LATENCY_EN
  input  logic        START,
  output logic [15:0] LATENCY,
`endif
  output logic        FRAME_OK,
  output logic        FRAME_BAD,
  output logic        ERR_STICKY,
  output logic [15:0] FRAME_CNT,
  output logic [15:0] ERR_CNT,
  output logic [15:0] LAST_LEN
);

  localparam logic [15:0] MAX_K = 16'(MAX_PAYLOAD);

  typedef enum logic {HUNT, BODY} state_t;

  state_t      state;
  logic [15:0] seq;
  logic [15:0] k;
  logic [15:0] cap;
  logic        cap_vld;
  logic        err;

  logic        beat;
  logic        keep_ok;
  logic        mism;
  logic        hdr_acc;
  logic        ok_n;
  logic        bad_n;
  logic        done_n;
  logic [15:0] seq_end;
  logic [31:0] exp_word;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign beat     = RX_TVALID & CHANNEL_UP;
  assign keep_ok  = (RX_TKEEP == 4'b1111);
  assign exp_word = {seq, k};
  assign mism     = (RX_DATA != exp_word);
  assign hdr_acc  = (state == HUNT) && beat && (RX_DATA == HEADER) && !RX_TLAST;
  // After a payload mismatch the sender's own sequence number is trusted for the next frame.
  assign seq_end  = cap_vld ? cap + 16'd1 : seq + 16'd1;

  always_comb begin
    ok_n   = 1'b0;
    bad_n  = 1'b0;
    done_n = 1'b0;
    if (state == HUNT) begin
      if (beat && (RX_DATA == HEADER) && RX_TLAST) bad_n = 1'b1;
    end else if (!CHANNEL_UP) begin
      bad_n = 1'b1;
    end else if (RX_TVALID) begin
      if (RX_TLAST) begin
        done_n = 1'b1;
        if (err || !keep_ok || (RX_DATA != TRAILER)) bad_n = 1'b1;
        else                                         ok_n  = 1'b1;
      end else if (k == MAX_K) begin
        bad_n = 1'b1;
      end
    end
  end

  // Frame state, per-frame result pulses and counters
  always_ff @(posedge USER_CLK or posedge RESET) begin
    if (RESET) begin
      state      <= HUNT;
      seq        <= '0;
      k          <= '0;
      cap        <= '0;
      cap_vld    <= 1'b0;
      err        <= 1'b0;
      FRAME_OK   <= 1'b0;
      FRAME_BAD  <= 1'b0;
      ERR_STICKY <= 1'b0;
      FRAME_CNT  <= '0;
      ERR_CNT    <= '0;
      LAST_LEN   <= '0;
    end else begin
      FRAME_OK  <= ok_n;
      FRAME_BAD <= bad_n;
      case (state)
        HUNT: begin
          if (hdr_acc) begin
            state   <= BODY;
            k       <= '0;
            err     <= !keep_ok;
            cap_vld <= 1'b0;
          end
        end
        BODY: begin
          if (!CHANNEL_UP) begin
            state <= HUNT;
          end else if (RX_TVALID) begin
            if (RX_TLAST) begin
              state    <= HUNT;
              LAST_LEN <= k;
            end else if (k == MAX_K) begin
              state <= HUNT;
            end else begin
              k <= k + 16'd1;
              if (mism || !keep_ok) err <= 1'b1;
              if (mism && !cap_vld) begin
                cap     <= RX_DATA[0:15];
                cap_vld <= 1'b1;
              end
            end
          end
        end
        default: state <= HUNT;
      endcase
      if (CLEAR) begin
        FRAME_CNT  <= '0;
        ERR_CNT    <= '0;
        ERR_STICKY <= 1'b0;
        seq        <= '0;
      end else begin
        if (ok_n) FRAME_CNT <= sat_inc(FRAME_CNT);
        if (bad_n) begin
          ERR_CNT    <= sat_inc(ERR_CNT);
          ERR_STICKY <= 1'b1;
        end
        if (done_n) seq <= seq_end;
      end
    end
  end

`ifdef CHECKER_LATENCY_EN
  logic [15:0] lat_cnt;
  logic        lat_run;

  // Latency counter: START restarts it, the next accepted header stops it
  always_ff @(posedge USER_CLK or posedge RESET) begin
    if (RESET) begin
      lat_cnt <= '0;
      lat_run <= 1'b0;
      LATENCY <= '0;
    end else if (START) begin
      lat_cnt <= '0;
      lat_run <= 1'b1;
    end else if (lat_run) begin
      if (hdr_acc) begin
        LATENCY <= sat_inc(lat_cnt);
        lat_run <= 1'b0;
      end else begin
        lat_cnt <= sat_inc(lat_cnt);
      end
    end
  end
`endif

endmodule

// File: tb/tb_aurora_rx_frame_checker.sv
// Bench for aurora_rx_frame_checker: frame-level reference model plus directed frames.
// Define CHECKER_LATENCY_EN for both files to include the latency measurement.
module tb_aurora_rx_frame_checker;

  localparam int MAXP = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cup;
  logic [0:31] data;
  logic        valid;
  logic [0:3]  keep;
  logic        last;
  logic        clr;
  logic        start;
  logic        frame_ok, frame_bad, err_sticky;
  logic [15:0] frame_cnt, err_cnt, last_len, latency;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aurora_rx_frame_checker #(
    .HEADER(32'hCAFEBABE), .TRAILER(32'hDEADBEEF), .MAX_PAYLOAD(MAXP)
  ) dut (
    .USER_CLK(clk), .RESET(rst), .CHANNEL_UP(cup), .RX_DATA(data),
    .RX_TVALID(valid), .RX_TKEEP(keep), .RX_TLAST(last), .CLEAR(clr),
`ifdef CHECKER_LATENCY_EN
    .START(start), .LATENCY(latency),
`endif
    .FRAME_OK(frame_ok), .FRAME_BAD(frame_bad), .ERR_STICKY(err_sticky),
    .FRAME_CNT(frame_cnt), .ERR_CNT(err_cnt), .LAST_LEN(last_len)
  );
`ifndef CHECKER_LATENCY_EN
  assign latency = 16'd0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collects a whole frame, judges it when the trailer arrives
  logic [31:0] pay[$];
  logic        m_in, m_keep, m_ok, m_bad, m_sticky, m_good;
  logic [15:0] m_seq, m_fcnt, m_ecnt, m_len, m_nseq, m_lat;
  int          m_first, cyc, start_cyc;
  logic        m_lrun;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pay.delete();
      m_in = 0; m_keep = 1; m_ok = 0; m_bad = 0; m_sticky = 0;
      m_seq = 0; m_fcnt = 0; m_ecnt = 0; m_len = 0; m_lat = 0;
      m_lrun = 0; cyc = 0; start_cyc = 0;
    end else begin
      cyc++;
      m_ok = 0; m_bad = 0; m_nseq = m_seq;
      if (!cup) begin
        if (m_in) m_bad = 1;
        m_in = 0;
      end else if (valid) begin
        if (!m_in) begin
          if (data == 32'hCAFEBABE) begin
            if (last) m_bad = 1;
            else begin
              m_in = 1; m_keep = (keep == 4'hF); pay.delete();
              if (m_lrun && !start) begin
                m_lat = (cyc - start_cyc > 65535) ? 16'hFFFF : 16'(cyc - start_cyc);
                m_lrun = 0;
              end
            end
          end
        end else if (!last) begin
          if (pay.size() == MAXP) begin m_bad = 1; m_in = 0; end
          else begin pay.push_back(data); if (keep != 4'hF) m_keep = 0; end
        end else begin
          m_good = m_keep && (keep == 4'hF) && (data == 32'hDEADBEEF);
          m_first = -1;
          for (int i = 0; i < pay.size(); i++)
            if (pay[i] != {m_seq, 16'(i)}) begin
              m_good = 0;
              if (m_first < 0) m_first = i;
            end
          m_ok = m_good; m_bad = !m_good;
          m_len = 16'(pay.size());
          m_nseq = (m_first >= 0) ? pay[m_first][31:16] + 16'd1 : m_seq + 16'd1;
          m_in = 0;
        end
      end
      if (start) begin start_cyc = cyc; m_lrun = 1; end
      if (clr) begin
        m_fcnt = 0; m_ecnt = 0; m_sticky = 0; m_seq = 0;
      end else begin
        if (m_ok && m_fcnt != 16'hFFFF) m_fcnt++;
        if (m_bad) begin
          if (m_ecnt != 16'hFFFF) m_ecnt++;
          m_sticky = 1;
        end
        m_seq = m_nseq;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("frame_ok", frame_ok, m_ok);
      chk("frame_bad", frame_bad, m_bad);
      chk("err_sticky", err_sticky, m_sticky);
      chk("frame_cnt", frame_cnt, m_fcnt);
      chk("err_cnt", err_cnt, m_ecnt);
      chk("last_len", last_len, m_len);
`ifdef CHECKER_LATENCY_EN
      chk("latency", latency, m_lat);
`endif
    end
  end

  task automatic beat(input logic [31:0] d, input logic l, input logic [3:0] kp = 4'hF);
    valid = 1; data = d; last = l; keep = kp;
    @(posedge clk); #1;
    valid = 0; last = 0; keep = 4'hF;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1; cup = 1; valid = 0; data = '0; keep = 4'hF; last = 0; clr = 0; start = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_ok", frame_ok, 0); chk("rst_bad", frame_bad, 0); chk("rst_sticky", err_sticky, 0);
    chk("rst_fcnt", frame_cnt, 0); chk("rst_ecnt", err_cnt, 0); chk("rst_len", last_len, 0);
    chk("rst_lat", latency, 0);
    idle();

    // Minimal frame with empty payload
    beat(32'hCAFEBABE, 0); beat(32'hDEADBEEF, 1);
    chk("t1_ok", frame_ok, 1); chk("t1_fcnt", frame_cnt, 1); chk("t1_len", last_len, 0);
    clr = 1; idle(); clr = 0;
    chk("clr1_fcnt", frame_cnt, 0);

    // Two back-to-back frames, seq 0 then 1
    beat(32'hCAFEBABE, 0); beat(32'h00000000, 0); beat(32'h00000001, 0); beat(32'hDEADBEEF, 1);
    chk("t2a_ok", frame_ok, 1);
    beat(32'hCAFEBABE, 0); beat(32'h00010000, 0); beat(32'hDEADBEEF, 1);
    chk("t2b_ok", frame_ok, 1); chk("t2_fcnt", frame_cnt, 2); chk("t2_len", last_len, 1);
    idle();
    chk("t2_pulse_end", frame_ok, 0);

    // Payload mismatch (expects 00020000), resync to seq 1
    beat(32'hCAFEBABE, 0); beat(32'h00000005, 0); beat(32'hDEADBEEF, 1);
    chk("t3_bad", frame_bad, 1); chk("t3_ecnt", err_cnt, 1); chk("t3_sticky", err_sticky, 1);
    beat(32'hCAFEBABE, 0); beat(32'h00010000, 0); beat(32'hDEADBEEF, 1);
    chk("t3_resync_ok", frame_ok, 1); chk("t3_fcnt", frame_cnt, 3);

    // Bad TKEEP on trailer, then channel drop mid-frame
    beat(32'hCAFEBABE, 0); beat(32'h00020000, 0); beat(32'hDEADBEEF, 1, 4'b0111);
    chk("t4_keep_bad", frame_bad, 1); chk("t4_ecnt", err_cnt, 2);
    beat(32'hCAFEBABE, 0); beat(32'h00030000, 0);
    cup = 0; idle();
    chk("t4_cup_bad", frame_bad, 1); chk("t4_cup_ecnt", err_cnt, 3);
    cup = 1; idle();
    beat(32'hCAFEBABE, 0); beat(32'h00030000, 0); beat(32'hDEADBEEF, 1);
    chk("t4_after_ok", frame_ok, 1); chk("t4_fcnt", frame_cnt, 4);

    // Stray beat ignored; header carrying TLAST is bad
    beat(32'h12345678, 0); idle();
    beat(32'hCAFEBABE, 1);
    chk("t5_hdr_last", frame_bad, 1); chk("t5_ecnt", err_cnt, 4);

    // Payload overflow with MAX_PAYLOAD=2; the orphan trailer is ignored
    beat(32'hCAFEBABE, 0); beat(32'h00040000, 0); beat(32'h00040001, 0); beat(32'h00040002, 0);
    chk("t6_ovf_bad", frame_bad, 1); chk("t6_ecnt", err_cnt, 5);
    beat(32'hDEADBEEF, 1);
    chk("t6_orphan_ok", frame_ok, 0); chk("t6_orphan_bad", frame_bad, 0);
    clr = 1; idle(); clr = 0;
    chk("t6_clr_ecnt", err_cnt, 0); chk("t6_clr_sticky", err_sticky, 0); chk("t6_clr_fcnt", frame_cnt, 0);

    // CLEAR coinciding with trailer: pulse kept, counters and seq cleared
    beat(32'hCAFEBABE, 0);
    clr = 1; beat(32'hDEADBEEF, 1); clr = 0;
    chk("t7_ok", frame_ok, 1); chk("t7_fcnt", frame_cnt, 0);
    beat(32'hCAFEBABE, 0); beat(32'h00000000, 0); beat(32'hDEADBEEF, 1);
    chk("t7_seq0_ok", frame_ok, 1); chk("t7_fcnt2", frame_cnt, 1); chk("t7_len", last_len, 1);

    // Reset in the middle of a frame: no pulse
    beat(32'hCAFEBABE, 0); beat(32'h00010000, 0);
    #1 rst = 1;
    idle(); rst = 0;
    chk("t8_ok", frame_ok, 0); chk("t8_bad", frame_bad, 0); chk("t8_fcnt", frame_cnt, 0);
    beat(32'hCAFEBABE, 0); beat(32'h00000000, 0); beat(32'hDEADBEEF, 1);
    chk("t8_after_ok", frame_ok, 1);

`ifdef CHECKER_LATENCY_EN
    // START sampled at edge n, header sampled at edge n+40
    start = 1; idle(); start = 0;
    repeat (39) idle();
    beat(32'hCAFEBABE, 0); beat(32'hDEADBEEF, 1);
    chk("t9_latency", latency, 40);
`endif
    idle(); idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
